// File: rtl/ula_pkg.sv
// ----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the bit-serial ALU:
//   - DEFAULT_WIDTH : default operand/result width
//   - alu_op_t      : 3-bit op codes (AND, OR, ADD, NOR, XOR, NAND, SUB, SLT)
//   - state_t       : control FSM states (IDLE, RUN, DONE)
//   - is_sub_op     : op needs inverted B and carry-in of 1 (SUB, SLT)
//   - is_arith_op   : op produces a meaningful carry-out (ADD, SUB, SLT)
// ----------------------------------------------------------------------------
package ula_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_NOR  = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_sub_op(input logic [2:0] op);
        return (op == 3'(ALU_SUB)) || (op == 3'(ALU_SLT));
    endfunction

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == 3'(ALU_ADD)) || (op == 3'(ALU_SUB)) || (op == 3'(ALU_SLT));
    endfunction

endpackage

// File: rtl/ula_serial_32_if.sv
// ----------------------------------------------------------------------------
// ula_serial_32_if
// Request/response bundle for the bit-serial ALU.
//   master (requester): drives start, alu_control, a, b
//                       reads busy, done, result, zero, carry_out, dbg_state
//   slave  (ALU)      : the reverse
//
// Handshake: a request is accepted on a rising clk edge where start=1 and the
// ALU is not busy (IDLE or DONE); a, b and alu_control are captured on that
// edge. start while busy=1 is dropped, not queued. done is a one-cycle pulse
// marking result/zero/carry_out valid; they then hold until the next
// accepted request completes. dbg_state mirrors the FSM state.
// ----------------------------------------------------------------------------
interface ula_serial_32_if
    import ula_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry_out;
    state_t           dbg_state;

    modport master (
        output start, alu_control, a, b,
        input  busy, done, result, zero, carry_out, dbg_state
    );

    modport slave (
        input  start, alu_control, a, b,
        output busy, done, result, zero, carry_out, dbg_state
    );
endinterface

// File: rtl/ULA_1bit.sv
// ----------------------------------------------------------------------------
// ULA_1bit
// One-bit ALU slice.
//   i_a, i_b        : operand bits
//   i_cin           : carry in
//   i_add_sub       : 1 inverts B for subtraction / compare
//   i_less          : value returned for SLT
//   i_alu_control   : op code (alu_op_t encoding)
//   o_result        : slice result bit
//   o_cout          : carry out of the adder
//   o_set           : raw adder sum, used as the sign bit for SLT on the MSB
// ----------------------------------------------------------------------------
module ULA_1bit
    import ula_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    input  logic       i_add_sub,
    input  logic       i_less,
    input  logic [2:0] i_alu_control,
    output logic       o_result,
    output logic       o_cout,
    output logic       o_set
);
    logic w_b_eff;
    logic w_sum;

    assign w_b_eff = i_b ^ i_add_sub;
    assign w_sum   = i_a ^ w_b_eff ^ i_cin;
    assign o_cout  = (i_a & w_b_eff) | (i_cin & (i_a ^ w_b_eff));
    assign o_set   = w_sum;

    always_comb begin
        o_result = 1'b0;
        case (i_alu_control)
            3'(ALU_AND):  o_result = i_a & i_b;
            3'(ALU_OR):   o_result = i_a | i_b;
            3'(ALU_ADD):  o_result = w_sum;
            3'(ALU_NOR):  o_result = ~(i_a | i_b);
            3'(ALU_XOR):  o_result = i_a ^ i_b;
            3'(ALU_NAND): o_result = ~(i_a & i_b);
            3'(ALU_SUB):  o_result = w_sum;
            3'(ALU_SLT):  o_result = i_less;
            default:      o_result = 1'b0;
        endcase
    end
endmodule

// File: rtl/ula_serial_32.sv
// ----------------------------------------------------------------------------
// ula_serial_32
// Bit-serial ALU: one ULA_1bit slice processes one operand bit per clock,
// LSB first, so an operation takes WIDTH cycles in RUN.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ula_serial_32_if slave (start, alu_control, a, b in;
//                busy, done, result, zero, carry_out, dbg_state out)
// Timing: start accepted at edge k -> done high in the cycle after edge
// k+WIDTH, with result/zero/carry_out valid and held afterwards.
// ----------------------------------------------------------------------------
module ula_serial_32
    import ula_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input logic            clk,
    input logic            rst_n,
    ula_serial_32_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    // Holds the WIDTH-1 bits already produced; the current slice bit is
    // appended combinationally so the finished word is available on the
    // last RUN cycle without an extra shift.
    logic [WIDTH-2:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry_out;

    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_cout;
    logic             w_set;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_final;

    assign w_accept = bus.start && (r_state != ST_RUN);
    assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

    ULA_1bit u_slice (
        .i_a           (r_a[r_cnt]),
        .i_b           (r_b[r_cnt]),
        .i_cin         (r_carry),
        .i_add_sub     (is_sub_op(r_op)),
        .i_less        (1'b0),
        .i_alu_control (r_op),
        .o_result      (w_bit),
        .o_cout        (w_cout),
        .o_set         (w_set)
    );

    assign w_shift_next = {w_bit, r_shift};
    // SLT reports only the sign of a-b taken from the MSB slice.
    assign w_final = (r_op == 3'(ALU_SLT)) ? {{(WIDTH-1){1'b0}}, w_set} : w_shift_next;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: w_next = bus.start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, bit counter, carry chain, shift and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_shift     <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_op    <= bus.alu_control;
            r_cnt   <= '0;
            r_carry <= is_sub_op(bus.alu_control);
        end else if (r_state == ST_RUN) begin
            r_shift <= w_shift_next[WIDTH-1:1];
            r_carry <= w_cout;
            if (w_last) begin
                r_result    <= w_final;
                r_zero      <= (w_final == '0);
                r_carry_out <= is_arith_op(r_op) ? w_cout : 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.carry_out = r_carry_out;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_ula_serial_32.sv
// ----------------------------------------------------------------------------
// tb_ula_serial_32
// Directed plus random stimulus for ula_serial_32. Expected {carry, zero,
// result} words come from a word-level reference model and are queued when
// a request is driven, then popped when done pulses.
// ----------------------------------------------------------------------------
module tb_ula_serial_32;
    import ula_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    ula_serial_32_if #(.WIDTH(W)) bus();

    ula_serial_32 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_exp;
    int           n_cmp  = 0;
    int           n_fail = 0;

    function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        c = 1'b0;
        s = '0;
        case (op)
            3'(ALU_AND):  r = a & b;
            3'(ALU_OR):   r = a | b;
            3'(ALU_NOR):  r = ~(a | b);
            3'(ALU_XOR):  r = a ^ b;
            3'(ALU_NAND): r = ~(a & b);
            3'(ALU_ADD): begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
            end
            3'(ALU_SUB): begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[W-1:0];
                c = s[W];
            end
            default: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = {{(W-1){1'b0}}, s[W-1]};
                c = s[W];
            end
        endcase
        return {c, (r == '0), r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        bus.start       = 1'b1;
        bus.alu_control = op;
        bus.a           = a;
        bus.b           = b;
        if (push) exp_q.push_back(model(op, a, b));
    endtask

    task automatic scramble();
        bus.a           = $urandom;
        bus.b           = $urandom;
        bus.alu_control = 3'($urandom_range(0, 7));
    endtask

    // Called at a negedge lat0 cycles after the start edge; waits (bounded)
    // for done and checks latency and the popped expected word.
    task automatic wait_done(input int lat0, input string tag);
        int           lat;
        logic [W+1:0] e;
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(W + 1));
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        check({tag, " result"}, 64'({bus.carry_out, bus.zero, bus.result}), 64'(e));
        check({tag, " busy at done"}, 64'(bus.busy), 64'(0));
        last_exp = e;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        @(negedge clk);
        drive(op, a, b, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy"}, 64'(bus.busy), 64'(1));
        scramble();
        wait_done(1, tag);
        @(negedge clk);
        check({tag, " done pulse"}, 64'(bus.done), 64'(0));
        check({tag, " hold"}, 64'({bus.carry_out, bus.zero, bus.result}), 64'(last_exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.alu_control = 3'b000;
        bus.a           = '0;
        bus.b           = '0;
        repeat (3) @(negedge clk);

        check("reset busy",      64'(bus.busy),      64'(0));
        check("reset done",      64'(bus.done),      64'(0));
        check("reset result",    64'(bus.result),    64'(0));
        check("reset zero",      64'(bus.zero),      64'(0));
        check("reset carry_out", 64'(bus.carry_out), 64'(0));
        check("reset state",     64'(bus.dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;

        // directed corner cases
        do_op(3'(ALU_ADD), 32'h0000_0005, 32'h0000_0003, "add 5+3");
        do_op(3'(ALU_SUB), 32'h0000_0007, 32'h0000_0007, "sub 7-7");
        do_op(3'(ALU_SLT), 32'hFFFF_FFFF, 32'h0000_0001, "slt -1<1");
        do_op(3'(ALU_SLT), 32'h0000_0001, 32'hFFFF_FFFF, "slt 1<-1");
        do_op(3'(ALU_ADD), 32'hFFFF_FFFF, 32'h0000_0001, "add wrap");
        do_op(3'(ALU_NOR), 32'h0000_0000, 32'h0000_0000, "nor 0,0");
        do_op(3'(ALU_AND), 32'hF0F0_A5A5, 32'hFF00_0FF0, "and");
        do_op(3'(ALU_XOR), 32'h1234_5678, 32'hFFFF_0000, "xor");
        do_op(3'(ALU_NAND), 32'hFFFF_FFFF, 32'hFFFF_FFFF, "nand all ones");
        do_op(3'(ALU_SUB), 32'h0000_0000, 32'h0000_0001, "sub borrow");

        // random operations
        for (int i = 0; i < 8; i++) begin
            do_op(3'($urandom_range(0, 7)), $urandom, $urandom, "random");
        end

        // start while busy is ignored; start in DONE chains a new operation
        @(negedge clk);
        drive(3'(ALU_ADD), 32'h1234_5678, 32'h1111_1111, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        drive(3'(ALU_SUB), 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy start state", 64'(bus.dbg_state), 64'(ST_RUN));
        scramble();
        wait_done(11, "start while busy");
        drive(3'(ALU_XOR), 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        check("done restart busy", 64'(bus.busy), 64'(1));
        check("done restart done", 64'(bus.done), 64'(0));
        scramble();
        wait_done(1, "done restart");
        @(negedge clk);
        check("done restart pulse", 64'(bus.done), 64'(0));

        // reset in the middle of RUN aborts the operation
        do_op(3'(ALU_OR), 32'hF0F0_0000, 32'h0000_0F0F, "or before reset");
        @(negedge clk);
        drive(3'(ALU_ADD), 32'h0000_1000, 32'h0000_2000, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy",      64'(bus.busy),      64'(0));
        check("abort done",      64'(bus.done),      64'(0));
        check("abort result",    64'(bus.result),    64'(0));
        check("abort zero",      64'(bus.zero),      64'(0));
        check("abort carry_out", 64'(bus.carry_out), 64'(0));
        check("abort state",     64'(bus.dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        check("no done after abort", 64'(seen), 64'(0));

        // start accepted on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'(ALU_NAND), 32'h0F0F_FFFF, 32'hFFFF_0000, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        check("post reset busy", 64'(bus.busy), 64'(1));
        scramble();
        wait_done(1, "post reset op");

        check("queue empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ula_serial_32.md
ULA_SERIAL_32 -- requirements
Module: ula_serial_32

Interface
REQ-001 The block SHALL declare parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port alu_control  input  3  op code (000 AND, 001 OR, 010 ADD, 011 NOR, 100 XOR, 101 NAND, 110 SUB, 111 SLT).
REQ-006 The block SHALL have ports a, b  input  WIDTH  operands, captured with start.
REQ-007 The block SHALL have port busy  output  1  high while in RUN.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-009 The block SHALL have port result  output  WIDTH  final result, held until next accepted start.
REQ-010 The block SHALL have ports zero, carry_out  output  1 each  result==0; final slice carry.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after bit WIDTH-1, DONE->IDLE, or DONE->RUN if start is high in DONE.
REQ-012 On an accepted start, a, b and alu_control SHALL be latched; bit counter cleared to 0; carry register loaded with 1 for SUB/SLT, else 0.
REQ-013 In RUN, bit i SHALL be processed per cycle LSB first: slice A=a[i], B=b[i], cin=carry reg, addSubSignal=1 for SUB/SLT else 0, less=0.
REQ-014 Each RUN cycle SHALL shift the slice result into result register MSB and slice cout into carry register.
REQ-015 Latency: start sampled at edge k SHALL yield done=1 during the cycle after edge k+WIDTH, with result valid that cycle.
REQ-016 For SLT the final result SHALL be {WIDTH-1 zeros, set of bit WIDTH-1} (sign of a-b, no overflow correction).
REQ-017 carry_out SHALL be the cout of bit WIDTH-1 for ADD/SUB/SLT and 0 for logic ops; zero SHALL be computed on the final result.
REQ-018 start while busy SHALL be ignored; latched operands SHALL not change mid-operation.
REQ-019 Input changes on a/b/alu_control outside an accepted start SHALL not affect result.
REQ-020 result, zero, carry_out SHALL hold their values from DONE through IDLE until the next operation completes.
REQ-021 Counter SHALL be $clog2(WIDTH) bits wide and SHALL not wrap beyond WIDTH-1 within one operation.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, zero=0, carry_out=0, counter=0, carry reg=0.
REQ-023 Reset during RUN SHALL abort the operation; no done pulse SHALL follow reset release without a new start.
REQ-024 After rst_n rises, start SHALL be accepted on the first clk edge.

Structure
REQ-025 Op-code enum (ALU_AND..ALU_SLT) and default WIDTH SHALL live in shared package ula_pkg.
REQ-026 Bit datapath SHALL instantiate exactly one existing ULA_1bit slice; no other arithmetic logic for the per-bit result.
REQ-027 FSM, counter, shift registers and flag logic SHALL reside in ula_serial_32 itself.

Verification
REQ-028 ADD a=0x0000_0005, b=0x0000_0003 -> done 33 cycles after start edge, result=0x0000_0008, carry_out=0, zero=0.
REQ-029 SUB a=0x0000_0007, b=0x0000_0007 -> result=0x0000_0000, zero=1, carry_out=1.
REQ-030 SLT a=0xFFFF_FFFF (-1), b=0x0000_0001 -> result=0x0000_0001; swapped operands -> result=0x0000_0000.
REQ-031 ADD a=0xFFFF_FFFF, b=0x0000_0001 -> result=0x0000_0000, carry_out=1, zero=1; NOR a=0, b=0 -> 0xFFFF_FFFF, carry_out=0.
REQ-032 start re-asserted with new operands at cycle 10 of RUN -> ignored, first result unchanged; start in DONE cycle -> second op begins, busy=1 next cycle.
REQ-033 rst_n pulsed low at RUN cycle 15 -> busy=0, result=0 immediately; no done until a new start completes.
